// File: rtl/ser_framer_8b.sv
// Byte-to-bit serializer framer: COM alignment train after reset, then payload or IDLE bytes MSB-first.
// Optional even-parity bit per frame when SER_PARITY_EN is defined (9-bit frames).
module ser_framer_8b #(
  parameter logic [7:0] COM_BYTE   = 8'hBC,
  parameter logic [7:0] IDLE_BYTE  = 8'h7C,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       C,
  input  logic       RN,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       ser_out,
  output logic       byte_start,
  output logic       active
);

`ifdef SER_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif
  localparam logic [3:0] LAST = 4'(FW - 1);

  typedef enum logic {SYNC, RUN} state_t;

  // Parity rides in the low bit of the frame so the MSB of sreg is always the line bit.
  function automatic logic [FW-1:0] frame(input logic [7:0] b);
`ifdef SER_PARITY_EN
    return {b, ^b};
`else
    return b;
`endif
  endfunction

  state_t        state, state_nxt;
  logic [FW-1:0] sreg, sreg_nxt;
  logic [3:0]    bitcnt, bitcnt_nxt;
  logic [3:0]    synccnt, synccnt_nxt;
  logic          act, act_nxt;
  logic          at_last;

  assign at_last = (bitcnt == LAST);

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state   <= SYNC;
      sreg    <= frame(COM_BYTE);
      bitcnt  <= 4'd0;
      synccnt <= 4'd0;
      act     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bitcnt  <= bitcnt_nxt;
      synccnt <= synccnt_nxt;
      act     <= act_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = {sreg[FW-2:0], 1'b0};
    bitcnt_nxt  = bitcnt + 4'd1;
    synccnt_nxt = synccnt;
    act_nxt     = act;
    if (at_last) begin
      bitcnt_nxt = 4'd0;
      case (state)
        SYNC: begin
          if (int'(synccnt) + 1 < SYNC_COUNT) begin
            sreg_nxt    = frame(COM_BYTE);
            synccnt_nxt = synccnt + 4'd1;
          end else begin
            sreg_nxt  = frame(IDLE_BYTE);
            state_nxt = RUN;
          end
        end
        RUN: begin
          // ready_out is high here, so valid_in alone decides the transfer.
          if (valid_in) begin
            sreg_nxt = frame(data_in);
            act_nxt  = 1'b1;
          end else begin
            sreg_nxt = frame(IDLE_BYTE);
            act_nxt  = 1'b0;
          end
        end
        default: begin
          state_nxt = SYNC;
        end
      endcase
    end
  end

  assign ready_out  = (state == RUN) && at_last;
  assign ser_out    = sreg[FW-1];
  assign byte_start = (bitcnt == 4'd0);
  assign active     = act;

endmodule

// File: tb/tb_ser_framer_8b.sv
// Scoreboard bench for ser_framer_8b: expected per-cycle {ser_out, byte_start, active, ready_out}
// are queued when a frame's content is decided and popped one per cycle on the falling edge.
module tb_ser_framer_8b;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int         SYNC = 4;

  logic       C = 1'b0;
  logic       RN;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, ser_out, byte_start, active;

  int compared = 0;
  int failed   = 0;
  logic [3:0] exp_q[$];

  ser_framer_8b dut (
    .C(C), .RN(RN), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .ser_out(ser_out), .byte_start(byte_start), .active(active)
  );

  always #5 C = ~C;

  // Expected line bits of one frame, MSB first, parity (XOR) last when enabled.
  function automatic void push_frame(input logic [7:0] b, input logic act, input logic rdy);
    for (int i = 0; i < FL; i++) begin
      logic bitv;
      bitv = (i < 8) ? b[7-i] : ^b;
      exp_q.push_back({bitv, (i == 0), act, rdy && (i == FL - 1)});
    end
  endfunction

  task automatic test_reset();
    logic [3:0] e;
    RN = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    exp_q.delete();
    repeat (2) @(posedge C);
    #1;
    compared++;
    if ({ser_out, byte_start, active, ready_out} !== 4'b1100) begin
      failed++;
      $display("FAIL reset_outputs: got %b want 1100", {ser_out, byte_start, active, ready_out});
    end
    @(posedge C);
    #1 RN = 1'b1;
    for (int f = 0; f < SYNC; f++) push_frame(COM, 1'b0, 1'b0);
    push_frame(IDLE, 1'b0, 1'b1);
    for (int c = 0; c < (SYNC + 1) * FL; c++) begin
      @(negedge C);
      if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 4'bxxxx;
      compared++;
      if ({ser_out, byte_start, active, ready_out} !== e) begin
        failed++;
        $display("FAIL sync_train cycle %0d: got %b want %b", c, {ser_out, byte_start, active, ready_out}, e);
      end
    end
    valid_in = 1'b0;
    push_frame(IDLE, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    logic [3:0] e;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FL; i++) begin
        @(negedge C);
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 4'bxxxx;
        compared++;
        if ({ser_out, byte_start, active, ready_out} !== e) begin
          failed++;
          $display("FAIL single_a5 f%0d b%0d: got %b want %b", f, i, {ser_out, byte_start, active, ready_out}, e);
        end
        valid_in = 1'b0;
        if (i == FL - 1) begin
          if (f == 0) begin
            valid_in = 1'b1; data_in = 8'hA5;
            push_frame(8'hA5, 1'b1, 1'b1);
          end else begin
            push_frame(IDLE, 1'b0, 1'b1);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FL; i++) begin
        @(negedge C);
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 4'bxxxx;
        compared++;
        if ({ser_out, byte_start, active, ready_out} !== e) begin
          failed++;
          $display("FAIL back_to_back f%0d b%0d: got %b want %b", f, i, {ser_out, byte_start, active, ready_out}, e);
        end
        if (i != FL - 1) begin
          if (f == 1) begin valid_in = 1'b1; data_in = 8'hFF; end
          else valid_in = 1'b0;
        end else if (f == 0) begin
          valid_in = 1'b1; data_in = 8'h01;
          push_frame(8'h01, 1'b1, 1'b1);
        end else if (f == 1) begin
          valid_in = 1'b1; data_in = 8'hFF;
          push_frame(8'hFF, 1'b1, 1'b1);
        end else begin
          valid_in = 1'b0;
          push_frame(IDLE, 1'b0, 1'b1);
        end
      end
    end
  endtask

  task automatic test_no_accept();
    logic [3:0] e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FL; i++) begin
        @(negedge C);
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 4'bxxxx;
        compared++;
        if ({ser_out, byte_start, active, ready_out} !== e) begin
          failed++;
          $display("FAIL no_accept f%0d b%0d: got %b want %b", f, i, {ser_out, byte_start, active, ready_out}, e);
        end
        data_in = 8'h3C;
        if (i != FL - 1) begin
          valid_in = i[0];
        end else begin
          valid_in = 1'b0;
          push_frame(IDLE, 1'b0, 1'b1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    // Frame 0 is IDLE and accepts A5 at its end; reset hits bit 3 of the A5 frame.
    for (int c = 0; c < FL + 4; c++) begin
      @(negedge C);
      if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 4'bxxxx;
      compared++;
      if ({ser_out, byte_start, active, ready_out} !== e) begin
        failed++;
        $display("FAIL pre_reset cycle %0d: got %b want %b", c, {ser_out, byte_start, active, ready_out}, e);
      end
      valid_in = 1'b0;
      if (c == FL - 1) begin
        valid_in = 1'b1; data_in = 8'hA5;
        push_frame(8'hA5, 1'b1, 1'b1);
      end
    end
    RN = 1'b0;
    #1;
    compared++;
    if ({ser_out, byte_start, active, ready_out} !== 4'b1100) begin
      failed++;
      $display("FAIL mid_reset_outputs: got %b want 1100", {ser_out, byte_start, active, ready_out});
    end
    exp_q.delete();
    repeat (2) @(posedge C);
    #1 RN = 1'b1;
    for (int f = 0; f < SYNC; f++) push_frame(COM, 1'b0, 1'b0);
    push_frame(IDLE, 1'b0, 1'b1);
    for (int c = 0; c < (SYNC + 2) * FL; c++) begin
      @(negedge C);
      if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 4'bxxxx;
      compared++;
      if ({ser_out, byte_start, active, ready_out} !== e) begin
        failed++;
        $display("FAIL restart cycle %0d: got %b want %b", c, {ser_out, byte_start, active, ready_out}, e);
      end
      valid_in = 1'b0;
      if (c % FL == FL - 1) push_frame(IDLE, 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_accept();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", compared);
    $fatal(1, "timeout");
  end

endmodule
